mesh_wormhole_switch_control: RTL and testbench

MESH_WORMHOLE_SWITCH_CONTROL -- requirements
Module: mesh_wormhole_switch_control

---
 rtl/mesh_wormhole_switch_control.sv | 117 +++++++++++
 tb/tb_mesh_wormhole_switch_control.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mesh_wormhole_switch_control.sv
// Wormhole switch allocator: per-output IDLE/LOCKED FSM with round-robin
// arbitration, packet locking until the tail flit, and credit-based flow control.
module mesh_wormhole_switch_control #(
  parameter int unsigned N       = 5,
  parameter int unsigned M       = 5,
  parameter int unsigned CREDITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N-1:0][M-1:0] i_output_req,
  input  logic [N-1:0]        i_tail,
  input  logic [M-1:0]        i_credit_return,
  output logic [M-1:0][N-1:0] o_output_grant,
  output logic [M-1:0]        o_locked
);

  localparam int unsigned CW = $clog2(CREDITS + 1);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t        r_state  [M];
  state_t        w_state_nxt [M];
  logic [IW-1:0] r_owner  [M];
  logic [IW-1:0] w_owner_nxt [M];
  logic [IW-1:0] r_ptr    [M];
  logic [IW-1:0] w_ptr_nxt [M];
  logic [CW-1:0] r_credit [M];
  logic [CW-1:0] w_credit_nxt [M];
  logic [N-1:0]  w_taken;

  // State, owner, pointer and credit registers for every output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int o = 0; o < int'(M); o++) begin
        r_state[o]  <= S_IDLE;
        r_owner[o]  <= '0;
        r_ptr[o]    <= '0;
        r_credit[o] <= CW'(CREDITS);
      end
    end else begin
      for (int o = 0; o < int'(M); o++) begin
        r_state[o]  <= w_state_nxt[o];
        r_owner[o]  <= w_owner_nxt[o];
        r_ptr[o]    <= w_ptr_nxt[o];
        r_credit[o] <= w_credit_nxt[o];
      end
    end
  end

  // Lock status follows the FSM state (cleared asynchronously by reset)
  always_comb begin
    o_locked = '0;
    for (int o = 0; o < int'(M); o++) begin
      o_locked[o] = (r_state[o] == S_LOCKED);
    end
  end

  // Arbitration and next-state; lower-index outputs claim inputs first
  always_comb begin : arb
    logic          w_hit;
    logic [IW-1:0] w_win;
    int            idx;
    o_output_grant = '0;
    w_taken        = '0;
    w_hit          = 1'b0;
    w_win          = '0;
    idx            = 0;
    for (int o = 0; o < int'(M); o++) begin
      w_state_nxt[o]  = r_state[o];
      w_owner_nxt[o]  = r_owner[o];
      w_ptr_nxt[o]    = r_ptr[o];
      w_credit_nxt[o] = r_credit[o];
    end
    for (int o = 0; o < int'(M); o++) begin
      w_hit = 1'b0;
      w_win = '0;
      if (r_state[o] == S_IDLE) begin
        // First requester at or after the pointer, cyclically
        for (int k = 0; k < int'(N); k++) begin
          idx = (int'(r_ptr[o]) + k) % int'(N);
          if (!w_hit && i_output_req[idx][o]) begin
            w_hit = 1'b1;
            w_win = IW'(idx);
          end
        end
      end else if (i_output_req[r_owner[o]][o]) begin
        w_hit = 1'b1;
        w_win = r_owner[o];
      end
      // No grant without credit, during reset, or when a lower output took the input
      if (r_credit[o] == '0 || !reset_n || w_taken[w_win]) begin
        w_hit = 1'b0;
      end
      if (w_hit) begin
        o_output_grant[o][w_win] = 1'b1;
        w_taken[w_win]           = 1'b1;
        if (r_state[o] == S_IDLE) begin
          w_ptr_nxt[o] = (w_win == IW'(N - 1)) ? '0 : w_win + IW'(1);
          if (!i_tail[w_win]) begin
            w_state_nxt[o] = S_LOCKED;
            w_owner_nxt[o] = w_win;
          end
        end else if (i_tail[w_win]) begin
          w_state_nxt[o] = S_IDLE;
        end
      end
      // Credit accounting; returns saturate at full depth
      if (w_hit && !i_credit_return[o]) begin
        w_credit_nxt[o] = r_credit[o] - CW'(1);
      end else if (!w_hit && i_credit_return[o] && r_credit[o] != CW'(CREDITS)) begin
        w_credit_nxt[o] = r_credit[o] + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mesh_wormhole_switch_control.sv
// Scoreboard bench: stimulus pushes per-cycle expectations, a negedge monitor checks them.
module tb_mesh_wormhole_switch_control;

  localparam int unsigned N       = 5;
  localparam int unsigned M       = 5;
  localparam int unsigned CREDITS = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [N-1:0][M-1:0] req;
  logic [N-1:0]        tail;
  logic [M-1:0]        cret;
  logic [M-1:0][N-1:0] grant;
  logic [M-1:0]        locked;

  mesh_wormhole_switch_control #(.N(N), .M(M), .CREDITS(CREDITS)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_output_req    (req),
    .i_tail          (tail),
    .i_credit_return (cret),
    .o_output_grant  (grant),
    .o_locked        (locked)
  );

  always #5 clk = ~clk;

  // ak: 0 none, 1 credit count of output ai, 2 pointer of output ai
  typedef struct {
    int               id;
    logic [M*N-1:0]   grant;
    logic [M-1:0]     locked;
    int               ak;
    int               ai;
    int               av;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   id_cnt   = 0;
  int   m_act;
  logic [M*N-1:0] m_flat;

  function automatic logic [M*N-1:0] g(input int o, input int i);
    logic [M*N-1:0] v;
    v = '0;
    v[o*N+i] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    req  = '0;
    tail = '0;
    cret = '0;
  endtask

  task automatic ex(input logic [M*N-1:0] eg, input logic [M-1:0] el,
                    input int ak = 0, input int ai = 0, input int av = 0);
    exp_t e;
    e.id = id_cnt; e.grant = eg; e.locked = el; e.ak = ak; e.ai = ai; e.av = av;
    id_cnt++;
    q.push_back(e);
  endtask

  // Monitor: pops one expectation per cycle and compares mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e    = q.pop_front();
      m_flat = grant;
      n_checks++;
      if (m_flat !== m_e.grant) begin
        n_fail++;
        $display("FAIL step%0d grant: got %h want %h", m_e.id, m_flat, m_e.grant);
      end
      n_checks++;
      if (locked !== m_e.locked) begin
        n_fail++;
        $display("FAIL step%0d locked: got %b want %b", m_e.id, locked, m_e.locked);
      end
      if (m_e.ak != 0) begin
        m_act = (m_e.ak == 1) ? int'(dut.r_credit[m_e.ai]) : int'(dut.r_ptr[m_e.ai]);
        n_checks++;
        if (m_act != m_e.av) begin
          n_fail++;
          $display("FAIL step%0d %s[%0d]: got %0d want %0d", m_e.id,
                   (m_e.ak == 1) ? "credit" : "ptr", m_e.ai, m_act, m_e.av);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    clr();
    // Reset: outputs forced low even with a pending request
    tick(); req[1][2] = 1'b1; ex('0, '0, 1, 2, 4);
    tick(); ex('0, '0, 2, 0, 0);
    tick(); reset_n = 1'b1; clr(); ex('0, '0, 1, 0, 4);

    // Contention: input 1 requests outputs 0 and 1; output 0 wins, output 1 untouched
    tick(); clr(); req[1][0] = 1'b1; req[1][1] = 1'b1; tail[1] = 1'b1; ex(g(0, 1), '0);
    tick(); clr(); cret[0] = 1'b1; ex('0, '0, 2, 1, 0);
    tick(); clr(); ex('0, '0, 1, 0, 4);

    // Round-robin on output 3 with single-flit packets
    for (int k = 0; k < 3; k++) begin
      tick(); clr();
      for (int i = 0; i < 3; i++) begin req[i][3] = 1'b1; tail[i] = 1'b1; end
      ex(g(3, k), '0);
    end
    tick(); clr(); cret[3] = 1'b1; ex('0, '0, 2, 3, 3);
    tick(); clr(); cret[3] = 1'b1; ex('0, '0, 1, 3, 2);
    tick(); clr(); cret[3] = 1'b1; ex('0, '0, 1, 3, 3);
    tick(); clr(); cret[3] = 1'b1; ex('0, '0, 1, 3, 4);
    tick(); clr(); ex('0, '0, 1, 3, 4);

    // Wormhole lock on output 2: input 1 packet, input 4 waits
    tick(); clr(); req[1][2] = 1'b1; req[4][2] = 1'b1; tail[4] = 1'b1; ex(g(2, 1), '0, 1, 2, 4);
    tick(); clr(); req[1][2] = 1'b1; req[4][2] = 1'b1; tail[4] = 1'b1; ex(g(2, 1), 5'b00100, 1, 2, 3);
    tick(); clr(); req[1][2] = 1'b1; req[4][2] = 1'b1; tail[4] = 1'b1; tail[1] = 1'b1;
    ex(g(2, 1), 5'b00100, 1, 2, 2);
    tick(); clr(); req[4][2] = 1'b1; tail[4] = 1'b1; ex(g(2, 4), '0, 1, 2, 1);
    tick(); clr(); req[0][2] = 1'b1; tail[0] = 1'b1; cret[2] = 1'b1; ex('0, '0, 1, 2, 0);
    tick(); clr(); req[0][2] = 1'b1; tail[0] = 1'b1; ex(g(2, 0), '0, 1, 2, 1);

    // Credit stall on output 1 streaming from input 0
    for (int k = 0; k < 4; k++) begin
      tick(); clr(); req[0][1] = 1'b1;
      ex(g(1, 0), (k == 0) ? 5'b00000 : 5'b00010, 1, 1, 4 - k);
    end
    tick(); clr(); req[0][1] = 1'b1; ex('0, 5'b00010, 1, 1, 0);
    tick(); clr(); req[0][1] = 1'b1; ex('0, 5'b00010, 1, 1, 0);
    tick(); clr(); req[0][1] = 1'b1; cret[1] = 1'b1; ex('0, 5'b00010, 1, 1, 0);
    tick(); clr(); req[0][1] = 1'b1; ex(g(1, 0), 5'b00010, 1, 1, 1);
    tick(); clr(); req[0][1] = 1'b1; ex('0, 5'b00010, 1, 1, 0);
    tick(); clr(); req[0][1] = 1'b1; cret[1] = 1'b1; ex('0, 5'b00010);
    tick(); clr(); req[0][1] = 1'b1; tail[0] = 1'b1; ex(g(1, 0), 5'b00010, 1, 1, 1);
    tick(); clr(); ex('0, '0, 1, 1, 0);

    // Simultaneous grant and return on output 4
    tick(); clr(); req[3][4] = 1'b1; tail[3] = 1'b1; ex(g(4, 3), '0, 1, 4, 4);
    tick(); clr(); req[3][4] = 1'b1; tail[3] = 1'b1; ex(g(4, 3), '0, 1, 4, 3);
    tick(); clr(); req[3][4] = 1'b1; tail[3] = 1'b1; cret[4] = 1'b1; ex(g(4, 3), '0, 1, 4, 2);
    tick(); clr(); cret[4] = 1'b1; ex('0, '0, 1, 4, 2);
    tick(); clr(); cret[4] = 1'b1; ex('0, '0, 1, 4, 3);
    tick(); clr(); ex('0, '0, 1, 4, 4);

    // Reset while output 0 is locked to input 3 at credit 1
    tick(); clr(); req[3][0] = 1'b1; ex(g(0, 3), '0, 1, 0, 4);
    tick(); clr(); req[3][0] = 1'b1; ex(g(0, 3), 5'b00001, 1, 0, 3);
    tick(); clr(); req[3][0] = 1'b1; ex(g(0, 3), 5'b00001, 1, 0, 2);
    tick(); clr(); req[2][0] = 1'b1; tail[2] = 1'b1; ex('0, 5'b00001, 1, 0, 1);
    tick(); reset_n = 1'b0; clr(); req[3][0] = 1'b1; req[2][0] = 1'b1; ex('0, '0, 1, 0, 4);
    tick(); ex('0, '0, 2, 0, 0);
    tick(); reset_n = 1'b1; clr(); req[2][0] = 1'b1; tail[2] = 1'b1; ex(g(0, 2), '0, 1, 0, 4);
    tick(); clr(); ex('0, '0, 2, 0, 3);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && q.size() > 0; k++) tick();
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
